mem_port_arbiter: RTL and testbench

//  Shares the single unified memory port between instruction fetch (IF) and data access (DM).

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arb_timer.sv | 27 ++
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and helpers for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_DM = 1'b1
  } arb_src_e;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Counter width that stays at least one bit when the range collapses to a single value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Loadable down-counter that times the BUSY hold; last flags the final held cycle.
module mem_arb_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch (IF) and data (DM) with DM priority and IF fairness.
// Optional MEM_ARB_PERF_EN adds saturating fetch-stall and DM-completion counters.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ARB_IDLE  | waiting for a request; grant decision and latch on request
//  ARB_BUSY  | strobe held MEM_LAT cycles; read data captured on last edge
//  ARB_DONE  | strobes low; winner's valid pulses for one cycle
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int FAIR_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pc_stall
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_dm_txn
`endif
);

  localparam int              LAT_W    = cnt_width(MEM_LAT);
  localparam int              FAIR_W   = $clog2(FAIR_LIMIT + 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(MEM_LAT - 1);
  localparam logic [FAIR_W-1:0] FAIR_MAX = FAIR_W'(FAIR_LIMIT);

  arb_state_e        state;
  arb_state_e        state_nxt;
  arb_src_e          grant_src;
  arb_src_e          lat_src;
  logic              grant;
  logic              busy;
  logic              lat_we;
  logic              lat_last;
  logic [FAIR_W-1:0] fair_cnt;

  assign grant = (state == ARB_IDLE) && (if_req || dm_req);
  assign busy  = (state == ARB_BUSY);

  // DM normally wins; a starved fetch takes the port once fair_cnt reaches the limit.
  assign grant_src = (dm_req && !(if_req && (fair_cnt == FAIR_MAX))) ? SRC_DM : SRC_IF;

  mem_arb_timer #(
    .W (LAT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (grant),
    .load_val (LAT_LOAD),
    .en       (busy),
    .last     (lat_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE: if (grant) state_nxt = ARB_BUSY;
      ARB_BUSY: if (lat_last) state_nxt = ARB_DONE;
      ARB_DONE: state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if_valid  = 1'b0;
    dm_valid  = 1'b0;
    case (state)
      ARB_BUSY: begin
        mem_read  = ~lat_we;
        mem_write = lat_we;
      end
      ARB_DONE: begin
        if_valid = (lat_src == SRC_IF);
        dm_valid = (lat_src == SRC_DM);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_src   <= SRC_IF;
      lat_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant) begin
      lat_src <= grant_src;
      if (grant_src == SRC_DM) begin
        lat_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end else begin
        lat_we   <= 1'b0;
        mem_addr <= if_addr;
      end
    end
  end

  // Stores never touch dm_rdata, so a store ack leaves the last load value visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata <= '0;
      dm_rdata <= '0;
    end else if (busy && lat_last && !lat_we) begin
      if (lat_src == SRC_IF) begin
        if_rdata <= mem_rdata;
      end else begin
        dm_rdata <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fair_cnt <= '0;
    end else if (grant) begin
      if ((grant_src == SRC_DM) && if_req) begin
        if (fair_cnt != FAIR_MAX) fair_cnt <= fair_cnt + FAIR_W'(1);
      end else begin
        fair_cnt <= '0;
      end
    end
  end

  assign pc_stall = if_req & ~if_valid;

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_stall <= '0;
      perf_dm_txn   <= '0;
    end else begin
      if (pc_stall && (perf_if_stall != '1)) perf_if_stall <= perf_if_stall + 32'd1;
      if (dm_valid && (perf_dm_txn != '1))   perf_dm_txn   <= perf_dm_txn + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance a (MEM_LAT=1, FAIR_LIMIT=2), instance b (MEM_LAT=3).
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        if_req_a, if_valid_a, dm_req_a, dm_we_a, dm_valid_a;
  logic        mem_read_a, mem_write_a, pc_stall_a;
  logic [31:0] if_addr_a, if_rdata_a, dm_addr_a, dm_wdata_a, dm_rdata_a;
  logic [31:0] mem_addr_a, mem_wdata_a, mem_rdata_a;

  logic        if_req_b, if_valid_b, dm_req_b, dm_we_b, dm_valid_b;
  logic        mem_read_b, mem_write_b, pc_stall_b;
  logic [31:0] if_addr_b, if_rdata_b, dm_addr_b, dm_wdata_b, dm_rdata_b;
  logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_stall_a, perf_dm_txn_a, perf_if_stall_b, perf_dm_txn_b;
  int          stall_mon;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_mon <= 0;
    else if (pc_stall_a) stall_mon <= stall_mon + 1;
  end
`endif

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  assign mem_rdata_a = mem_a[mem_addr_a[9:2]];
  assign mem_rdata_b = mem_b[mem_addr_b[9:2]];
  always @(posedge clk) if (mem_write_b) mem_b[mem_addr_b[9:2]] = mem_wdata_b;

  mem_port_arbiter #(.MEM_LAT(1), .FAIR_LIMIT(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req_a), .if_addr(if_addr_a), .if_valid(if_valid_a), .if_rdata(if_rdata_a),
    .dm_req(dm_req_a), .dm_we(dm_we_a), .dm_addr(dm_addr_a), .dm_wdata(dm_wdata_a),
    .dm_valid(dm_valid_a), .dm_rdata(dm_rdata_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_read(mem_read_a),
    .mem_write(mem_write_a), .mem_rdata(mem_rdata_a), .pc_stall(pc_stall_a)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_stall(perf_if_stall_a), .perf_dm_txn(perf_dm_txn_a)
`endif
  );

  mem_port_arbiter #(.MEM_LAT(3), .FAIR_LIMIT(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_valid(if_valid_b), .if_rdata(if_rdata_b),
    .dm_req(dm_req_b), .dm_we(dm_we_b), .dm_addr(dm_addr_b), .dm_wdata(dm_wdata_b),
    .dm_valid(dm_valid_b), .dm_rdata(dm_rdata_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_read(mem_read_b),
    .mem_write(mem_write_b), .mem_rdata(mem_rdata_b), .pc_stall(pc_stall_b)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_stall(perf_if_stall_b), .perf_dm_txn(perf_dm_txn_b)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic vsel(input int sel);
    case (sel)
      0:       return if_valid_a;
      1:       return dm_valid_a;
      2:       return if_valid_b;
      default: return dm_valid_b;
    endcase
  endfunction

  // Waits (bounded) for the selected valid; an expired wait reports cyc=999.
  task automatic wait_v(input int sel, output int cyc, output int wr);
    cyc = 0;
    wr  = 0;
    do begin
      tick();
      cyc++;
      if (mem_write_b) wr++;
    end while (!vsel(sel) && cyc < 30);
    if (!vsel(sel)) cyc = 999;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          cyc, wr, nv;
    logic [5:0]  seq;
    logic        stale;

    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'hA000_0000 + 32'(i);
      mem_b[i] = 32'hB000_0000 + 32'(i);
    end
    {if_req_a, dm_req_a, dm_we_a, if_req_b, dm_req_b, dm_we_b} = '0;
    {if_addr_a, dm_addr_a, dm_wdata_a, if_addr_b, dm_addr_b, dm_wdata_b} = '0;
    rst_n = 1'b0;
    #12;
    chk("rst_if_valid",  32'(if_valid_a), 32'd0);
    chk("rst_dm_valid",  32'(dm_valid_a), 32'd0);
    chk("rst_mem_read",  32'(mem_read_a), 32'd0);
    chk("rst_mem_write", 32'(mem_write_a), 32'd0);
    chk("rst_if_rdata",  if_rdata_a, 32'd0);
    chk("rst_mem_addr",  mem_addr_a, 32'd0);
    chk("rst_pc_stall",  32'(pc_stall_a), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: fetch only, MEM_LAT=1
    if_addr_a = 32'h0;
    if_req_a  = 1'b1;
    #1;
    chk("t1_stall_req", 32'(pc_stall_a), 32'd1);
    tick();
    chk("t1_mem_read", 32'(mem_read_a), 32'd1);
    chk("t1_mem_addr", mem_addr_a, 32'h0);
    chk("t1_stall_busy", 32'(pc_stall_a), 32'd1);
    tick();
    chk("t1_if_valid", 32'(if_valid_a), 32'd1);
    chk("t1_if_rdata", if_rdata_a, 32'hA000_0000);
    chk("t1_read_done", 32'(mem_read_a), 32'd0);
    chk("t1_stall_done", 32'(pc_stall_a), 32'd0);
    if_req_a = 1'b0;
    tick();
    chk("t1_valid_pulse", 32'(if_valid_a), 32'd0);

    // 2: simultaneous requests, DM served first
    if_addr_a = 32'h8;
    if_req_a  = 1'b1;
    dm_addr_a = 32'h100;
    dm_we_a   = 1'b0;
    dm_req_a  = 1'b1;
    wait_v(1, cyc, wr);
    chk("t2_dm_lat", 32'(cyc), 32'd2);
    chk("t2_dm_rdata", dm_rdata_a, 32'hA000_0040);
    chk("t2_if_not_yet", 32'(if_valid_a), 32'd0);
    chk("t2_stall", 32'(pc_stall_a), 32'd1);
    dm_req_a = 1'b0;
    wait_v(0, cyc, wr);
    chk("t2_if_after_dm", 32'(cyc), 32'd3);
    chk("t2_if_rdata", if_rdata_a, 32'hA000_0002);
    if_req_a = 1'b0;
    tick();

    // 3: store on MEM_LAT=3, bracketed by loads
    dm_addr_b = 32'h80;
    dm_we_b   = 1'b0;
    dm_req_b  = 1'b1;
    wait_v(3, cyc, wr);
    chk("t3_load_lat", 32'(cyc), 32'd4);
    chk("t3_load_data", dm_rdata_b, 32'hB000_0020);
    dm_req_b = 1'b0;
    tick();
    dm_addr_b  = 32'h40;
    dm_wdata_b = 32'hDEAD_BEEF;
    dm_we_b    = 1'b1;
    dm_req_b   = 1'b1;
    wait_v(3, cyc, wr);
    chk("t3_store_lat", 32'(cyc), 32'd4);
    chk("t3_write_cycles", 32'(wr), 32'd3);
    chk("t3_rdata_kept", dm_rdata_b, 32'hB000_0020);
    chk("t3_write_done", 32'(mem_write_b), 32'd0);
    dm_req_b = 1'b0;
    tick();
    dm_we_b  = 1'b0;
    dm_req_b = 1'b1;
    wait_v(3, cyc, wr);
    chk("t3_readback", dm_rdata_b, 32'hDEAD_BEEF);
    dm_req_b = 1'b0;
    tick();

    // 4: fairness with FAIR_LIMIT=2, both requests held
    if_addr_a = 32'hC;
    if_req_a  = 1'b1;
    dm_addr_a = 32'h100;
    dm_req_a  = 1'b1;
    seq = '0;
    nv  = 0;
    for (int c = 0; c < 60 && nv < 6; c++) begin
      tick();
      if (dm_valid_a) begin
        seq = {seq[4:0], 1'b1};
        nv++;
      end else if (if_valid_a) begin
        seq = {seq[4:0], 1'b0};
        nv++;
      end
    end
    chk("t4_count", 32'(nv), 32'd6);
    chk("t4_order", 32'(seq), 32'h36);
    if_req_a = 1'b0;
    dm_req_a = 1'b0;
    tick();
    tick();

    // 5: async reset mid-BUSY
    if_addr_a = 32'h10;
    if_req_a  = 1'b1;
    dm_addr_b = 32'h84;
    dm_req_b  = 1'b1;
    tick();
    chk("t5_busy_a", 32'(mem_read_a), 32'd1);
    chk("t5_busy_b", 32'(mem_read_b), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_read_a", 32'(mem_read_a), 32'd0);
    chk("t5_rst_read_b", 32'(mem_read_b), 32'd0);
    chk("t5_rst_addr_a", mem_addr_a, 32'd0);
    chk("t5_rst_valid_a", 32'(if_valid_a), 32'd0);
    if_req_a = 1'b0;
    dm_req_b = 1'b0;
    tick();
    rst_n = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      stale |= if_valid_a | dm_valid_a | if_valid_b | dm_valid_b;
    end
    chk("t5_no_stale", 32'(stale), 32'd0);
    if_req_a = 1'b1;
    wait_v(0, cyc, wr);
    chk("t5_refetch_lat", 32'(cyc), 32'd2);
    chk("t5_refetch_data", if_rdata_a, 32'hA000_0004);
    if_req_a = 1'b0;
    tick();

`ifdef MEM_ARB_PERF_EN
    // 6: perf counters (cleared by the reset above)
    for (int k = 0; k < 5; k++) begin
      dm_addr_a = 32'h200 + 32'(4 * k);
      dm_req_a  = 1'b1;
      wait_v(1, cyc, wr);
      chk("t6_load_lat", 32'(cyc), 32'd2);
      dm_req_a = 1'b0;
      tick();
    end
    chk("t6_perf_dm_txn", perf_dm_txn_a, 32'd5);
    chk("t6_perf_if_stall", perf_if_stall_a, 32'(stall_mon));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
